mem_arbiter: RTL

Shares the single data-memory port between the instruction-fetch stage and the execute stage's load/store request (`mem_ena`/`mem_rw`/`mem_addr`/`mem_data`). It sequences one transaction at a time to a memory with a variable-latency acknowledge. It returns read data and a one-cycle ready pulse to the winning requester. It raises a stall to the pipeline while an execute-stage access is outstanding. It sits between the EX/MEM boundary and the memory/bus wrapper.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state codes and grant encodings for the data-memory arbiter.
// Build option MEM_ARB_FAIR_EN selects round-robin tie-break instead of EX-first.
package mem_arbiter_pkg;

    localparam int DATA_BUS      = 32;
    localparam int ARB_STATE_BUS = 2;

    localparam logic [ARB_STATE_BUS-1:0] ARB_IDLE    = 2'd0;
    localparam logic [ARB_STATE_BUS-1:0] ARB_BUSY_EX = 2'd1;
    localparam logic [ARB_STATE_BUS-1:0] ARB_BUSY_IF = 2'd2;

    localparam logic ARB_GRANT_IF = 1'b0;
    localparam logic ARB_GRANT_EX = 1'b1;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    localparam logic ENABLE    = 1'b1;

    localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

    typedef struct packed {
        logic ex;
        logic fetch;
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the memory arbiter.
// MEM_ARB_FAIR_EN: ties go to the requester not granted last; else EX wins.
import mem_arbiter_pkg::*;

module mem_arb_pick (
    input  logic   if_elig_i,
    input  logic   ex_elig_i,
    input  logic   last_grant_i,
    output grant_t grant_o
);

`ifndef MEM_ARB_FAIR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

    always_comb begin
        grant_o = '0;
        if (ex_elig_i && if_elig_i) begin
`ifdef MEM_ARB_FAIR_EN
            if (last_grant_i == ARB_GRANT_EX) begin
                grant_o.fetch = 1'b1;
            end else begin
                grant_o.ex = 1'b1;
            end
`else
            // EX holds the older instruction
            grant_o.ex = 1'b1;
`endif
        end else begin
            grant_o.ex    = ex_elig_i;
            grant_o.fetch = if_elig_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the data-memory port between fetch and EX, one transaction at a time.
// Build option MEM_ARB_FAIR_EN adds a last-grant register for round-robin ties.
import mem_arbiter_pkg::*;

module mem_arbiter (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [DATA_BUS-1:0] if_addr_i,
    output logic [DATA_BUS-1:0] if_rdata_o,
    output logic                if_ready_o,
    input  logic                ex_mem_ena_i,
    input  logic                ex_mem_rw_i,
    input  logic [DATA_BUS-1:0] ex_mem_addr_i,
    input  logic [DATA_BUS-1:0] ex_mem_data_i,
    output logic [DATA_BUS-1:0] ex_rdata_o,
    output logic                ex_ready_o,
    output logic                stall_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [DATA_BUS-1:0] mem_addr_o,
    output logic [DATA_BUS-1:0] mem_wdata_o,
    input  logic [DATA_BUS-1:0] mem_rdata_i,
    input  logic                mem_ack_i
);

    logic [ARB_STATE_BUS-1:0] state_q, state_d;
    logic                     mem_ce_q, mem_ce_d;
    logic                     mem_we_q, mem_we_d;
    logic [DATA_BUS-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_BUS-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_BUS-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_BUS-1:0]      ex_rdata_q, ex_rdata_d;
    logic                     if_ready_q, if_ready_d;
    logic                     ex_ready_q, ex_ready_d;
    logic                     last_grant;
    logic                     if_elig, ex_elig;
    grant_t                   grant;

`ifdef MEM_ARB_FAIR_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = ARB_GRANT_IF;
`endif

    // A requester whose ready is pulsing this cycle is finishing, not asking
    assign if_elig = if_req_i & ~if_ready_q;
    assign ex_elig = ex_mem_ena_i & ~ex_ready_q;

    mem_arb_pick u_pick (
        .if_elig_i    (if_elig),
        .ex_elig_i    (ex_elig),
        .last_grant_i (last_grant),
        .grant_o      (grant)
    );

    always_comb begin
        state_d     = state_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        ex_rdata_d  = ex_rdata_q;
        if_ready_d  = 1'b0;
        ex_ready_d  = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (grant.ex) begin
                    state_d     = ARB_BUSY_EX;
                    mem_ce_d    = ENABLE;
                    mem_we_d    = ex_mem_rw_i;
                    mem_addr_d  = ex_mem_addr_i;
                    mem_wdata_d = ex_mem_data_i;
`ifdef MEM_ARB_FAIR_EN
                    last_grant_d = ARB_GRANT_EX;
`endif
                end else if (grant.fetch) begin
                    state_d     = ARB_BUSY_IF;
                    mem_ce_d    = ENABLE;
                    mem_we_d    = MEM_READ;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = DATA_ZERO;
`ifdef MEM_ARB_FAIR_EN
                    last_grant_d = ARB_GRANT_IF;
`endif
                end
            end
            ARB_BUSY_EX: begin
                if (mem_ack_i) begin
                    ex_rdata_d = (mem_we_q == MEM_WRITE) ? DATA_ZERO
                                                         : mem_rdata_i;
                    ex_ready_d = 1'b1;
                    mem_ce_d   = 1'b0;
                    state_d    = ARB_IDLE;
                end
            end
            ARB_BUSY_IF: begin
                if (mem_ack_i) begin
                    if_rdata_d = mem_rdata_i;
                    if_ready_d = 1'b1;
                    mem_ce_d   = 1'b0;
                    state_d    = ARB_IDLE;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                mem_ce_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= DATA_ZERO;
            mem_wdata_q <= DATA_ZERO;
            if_rdata_q  <= DATA_ZERO;
            ex_rdata_q  <= DATA_ZERO;
            if_ready_q  <= 1'b0;
            ex_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            ex_rdata_q  <= ex_rdata_d;
            if_ready_q  <= if_ready_d;
            ex_ready_q  <= ex_ready_d;
        end
    end

`ifdef MEM_ARB_FAIR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ARB_GRANT_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign ex_rdata_o  = ex_rdata_q;
    assign ex_ready_o  = ex_ready_q;
    assign stall_o     = ex_mem_ena_i & ~ex_ready_q;
    assign mem_ce_o    = mem_ce_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
